// File: rtl/stack_controller_if.sv
// Request/response bundle between the multicycle controller and the operand stack.
// master: controller side (drives requests, receives read data and status).
// slave : stack_controller side.
//   push/pop/top/flush/clr_err : single-cycle request strobes
//   din                        : push data
//   dout/valid                 : read data and its one-cycle update pulse
//   count/empty/full           : occupancy status
//   overflow/underflow         : sticky error flags
interface stack_controller_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic             push;
  logic             pop;
  logic             top;
  logic             flush;
  logic             clr_err;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             valid;
  logic [AW:0]      count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, top, flush, clr_err, din,
    input  dout, valid, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, top, flush, clr_err, din,
    output dout, valid, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/stack_controller.sv
// Hardware operand stack: owns storage and stack pointer, services one
// request per cycle (flush > push > pop > top), returns read data with
// one-cycle latency and keeps sticky overflow/underflow flags.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : stack_controller_if.slave (requests in, data/status out)
module stack_controller #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  stack_controller_if.slave  bus
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] SP_ONE  = (AW+1)'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t           state;
  logic [AW:0]      sp;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] dout_q;
  logic             ovf_q;
  logic             unf_q;

  logic             is_empty;
  logic             is_full;
  logic             do_flush;
  logic             do_push;
  logic             do_pop;
  logic             do_read;
  logic             set_ovf;
  logic             set_unf;
  logic [AW:0]      sp_dec;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;

  // Request arbitration and error detection; dropped requests have no effect.
  always_comb begin
    is_empty = (sp == '0);
    is_full  = (sp == SP_FULL);
    sp_dec   = sp - SP_ONE;
    wr_idx   = sp[AW-1:0];
    rd_idx   = sp_dec[AW-1:0];
    do_flush = 1'b0;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    do_read  = 1'b0;
    set_ovf  = 1'b0;
    set_unf  = 1'b0;
    if (bus.flush) begin
      do_flush = 1'b1;
    end else if (bus.push) begin
      if (is_full) set_ovf = 1'b1;
      else         do_push = 1'b1;
    end else if (bus.pop) begin
      if (is_empty) begin
        set_unf = 1'b1;
      end else begin
        do_pop  = 1'b1;
        do_read = 1'b1;
      end
    end else if (bus.top) begin
      if (is_empty) set_unf = 1'b1;
      else          do_read = 1'b1;
    end
  end

  // Storage array is deliberately not reset; it is never read before written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= bus.din;
  end

  // Pointer, read data, response state and sticky flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      sp     <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      state <= do_read ? RESP : IDLE;

      if (do_flush)     sp <= '0;
      else if (do_push) sp <= sp + SP_ONE;
      else if (do_pop)  sp <= sp_dec;

      if (do_read) dout_q <= mem[rd_idx];

      // A new error in the same cycle as clr_err wins for that flag.
      if (set_ovf)          ovf_q <= 1'b1;
      else if (bus.clr_err) ovf_q <= 1'b0;

      if (set_unf)          unf_q <= 1'b1;
      else if (bus.clr_err) unf_q <= 1'b0;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.valid     = (state == RESP);
  assign bus.count     = sp;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;

endmodule

// File: tb/tb_stack_controller.sv
// Testbench for stack_controller: directed requests, expected read data
// queued at issue time and matched by an independent valid-driven monitor.
module tb_stack_controller;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;

  logic clk;
  logic rst;

  stack_controller_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  stack_controller #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [WIDTH-1:0] exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: every valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'(bus.dout), 32'hFFFF_FFFF);
      end else begin
        chk("scoreboard_dout", 32'(bus.dout), 32'(exp_q.pop_front()));
      end
    end
  end

  // One request cycle: drive, take the edge, release strobes #1 after it.
  task automatic cyc(input logic p, input logic po, input logic tp, input logic fl,
                     input logic ce, input logic [WIDTH-1:0] d);
    bus.push = p; bus.pop = po; bus.top = tp; bus.flush = fl; bus.clr_err = ce; bus.din = d;
    @(posedge clk);
    #1;
    bus.push = 1'b0; bus.pop = 1'b0; bus.top = 1'b0; bus.flush = 1'b0; bus.clr_err = 1'b0;
  endtask

  task automatic do_push(input logic [WIDTH-1:0] d);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, d);
  endtask

  task automatic do_pop(input logic [WIDTH-1:0] exp);
    exp_q.push_back(exp);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("pop_valid", 32'(bus.valid), 32'd1);
  endtask

  task automatic do_top(input logic [WIDTH-1:0] exp);
    exp_q.push_back(exp);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    chk("top_valid", 32'(bus.valid), 32'd1);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, 32'(bus.count), 32'd0);
    chk({tag, "_empty"}, 32'(bus.empty), 32'd1);
    chk({tag, "_full"},  32'(bus.full),  32'd0);
    chk({tag, "_dout"},  32'(bus.dout),  32'd0);
    chk({tag, "_valid"}, 32'(bus.valid), 32'd0);
    chk({tag, "_ovf"},   32'(bus.overflow),  32'd0);
    chk({tag, "_unf"},   32'(bus.underflow), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    bus.push = 1'b0; bus.pop = 1'b0; bus.top = 1'b0; bus.flush = 1'b0; bus.clr_err = 1'b0;
    bus.din = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst = 1'b1;
    idle();

    // LIFO order with back-to-back pops
    do_push(8'h11); do_push(8'h22); do_push(8'h33);
    chk("lifo_count3", 32'(bus.count), 32'd3);
    do_pop(8'h33); do_pop(8'h22); do_pop(8'h11);
    chk("lifo_empty", 32'(bus.empty), 32'd1);
    idle();
    chk("lifo_valid_drop", 32'(bus.valid), 32'd0);

    // top leaves the stack unchanged
    do_push(8'h5A);
    do_top(8'h5A);
    do_top(8'h5A);
    chk("top_count1", 32'(bus.count), 32'd1);
    do_pop(8'h5A);
    chk("top_count0", 32'(bus.count), 32'd0);

    // fill, then push while full
    for (int i = 0; i < 16; i++) do_push(WIDTH'(i));
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_ovf_clear", 32'(bus.overflow), 32'd0);
    do_push(8'hFF);
    chk("ovf_set", 32'(bus.overflow), 32'd1);
    chk("ovf_count16", 32'(bus.count), 32'd16);
    chk("ovf_full", 32'(bus.full), 32'd1);
    do_pop(8'h0F);
    chk("ovf_count15", 32'(bus.count), 32'd15);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    chk("flush_count0", 32'(bus.count), 32'd0);
    chk("flush_keeps_ovf", 32'(bus.overflow), 32'd1);

    // underflow and sticky-flag clearing
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("unf_valid0", 32'(bus.valid), 32'd0);
    chk("unf_dout_held", 32'(bus.dout), 32'h0F);
    chk("unf_set", 32'(bus.underflow), 32'd1);
    chk("unf_count0", 32'(bus.count), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    chk("clr_unf", 32'(bus.underflow), 32'd0);
    chk("clr_ovf", 32'(bus.overflow), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    chk("top_empty_unf", 32'(bus.underflow), 32'd1);
    chk("top_empty_valid0", 32'(bus.valid), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0);
    chk("clr_vs_set_unf", 32'(bus.underflow), 32'd1);
    chk("clr_vs_set_ovf", 32'(bus.overflow), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);

    // priority: push beats pop, flush beats push
    do_push(8'h11); do_push(8'h22);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h44);
    chk("prio_push_count3", 32'(bus.count), 32'd3);
    chk("prio_push_valid0", 32'(bus.valid), 32'd0);
    do_pop(8'h44);
    chk("prio_count2", 32'(bus.count), 32'd2);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h77);
    chk("prio_flush_count0", 32'(bus.count), 32'd0);
    chk("prio_flush_valid0", 32'(bus.valid), 32'd0);

    // reset while a response is being presented
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("pre_rst_unf", 32'(bus.underflow), 32'd1);
    for (int i = 1; i <= 5; i++) do_push(WIDTH'(i));
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("pre_rst_valid", 32'(bus.valid), 32'd1);
    chk("pre_rst_dout", 32'(bus.dout), 32'h05);
    chk("pre_rst_count", 32'(bus.count), 32'd4);
    rst = 1'b0;
    #1;
    chk_reset_state("midrst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    do_push(8'h01);
    do_pop(8'h01);
    idle();
    idle();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stack_controller.md
# stack_controller

Sequencing and bookkeeping unit for the processor's hardware operand stack. It accepts single-cycle push/pop/top requests from the multicycle controller and owns the stack storage and stack pointer. It returns read data to the datapath with fixed one-cycle latency and reports full/empty plus sticky overflow/underflow errors. It sits between the controller's stack strobes and the datapath's A/ALU operand path.

## Interface
Parameters:
- WIDTH, 8, data word width (matches 8-bit instruction/data path)
- DEPTH, 16, stack entries; power of two, >= 2
- AW, $clog2(DEPTH), pointer width (derived; not overridden)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset asserted); release is synchronous to clk
- push  in  1  request: write din on top of stack
- pop  in  1  request: read top entry and remove it
- top  in  1  request: read top entry, stack unchanged
- flush  in  1  request: discard all entries
- clr_err  in  1  clear sticky error flags
- din  in  WIDTH  push data
- dout  out  WIDTH  read data from last successful pop/top; held otherwise
- valid  out  1  one-cycle pulse: dout updated this cycle
- count  out  AW+1  number of stored entries, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- overflow  out  1  sticky: push attempted while full
- underflow  out  1  sticky: pop/top attempted while empty

## Operation
- Storage: DEPTH x WIDTH register array, index 0 = bottom; sp register = count; top entry at mem[sp-1].
- One request serviced per cycle; priority flush > push > pop > top; lower-priority requests in the same cycle are dropped silently (no error flag, no effect).
- flush: sp <= 0; array contents not cleared; valid 0; errors unaffected.
- push, not full: mem[sp] <= din, sp <= sp+1. Push when full: no write, sp unchanged, overflow <= 1.
- pop, not empty: dout <= mem[sp-1], sp <= sp-1, valid pulses. Pop when empty: dout held, sp unchanged, valid 0, underflow <= 1.
- top, not empty: dout <= mem[sp-1], valid pulses, sp unchanged. Top when empty: as pop-when-empty.
- clr_err: overflow, underflow <= 0, unless a new error occurs the same cycle, in which case that flag is set (set wins); other flag cleared.
- Internal state machine: IDLE (no pending response) and RESP (valid asserted). A successful pop/top in any state goes to RESP; otherwise IDLE. Back-to-back reads keep RESP with new data each cycle.
- count, empty, full are combinational from sp; sp never leaves 0..DEPTH; pointer arithmetic in AW+1 bits, no wrap.

## Timing
- Requests sampled on rising edge N; effects (sp, mem, flags) visible after edge N.
- Read latency 1: pop/top sampled at edge N -> dout/valid valid during cycle N..N+1, valid low again after edge N+1 unless another read.
- Push at edge N, pop at edge N+1 returns the value pushed at N (no bypass needed; write completes at N).
- Reset (rst = 0, any time, including mid-response): sp=0, dout=0, valid=0, overflow=0, underflow=0, state IDLE; hence count=0, empty=1, full=0. Array contents undefined after reset; never read before written.
- No combinational path from request inputs to outputs except via sp-derived count/empty/full after the edge.

## Test plan
- Reset then push 0x11, 0x22, 0x33 on consecutive cycles -> count=3; pop, pop, pop back-to-back -> dout 0x33, 0x22, 0x11 with valid high three consecutive cycles, then empty=1.
- Push 0x5A, top twice -> dout=0x5A both times, count stays 1; pop -> 0x5A, count 0.
- Fill DEPTH=16 with 0..15, then push 0xFF -> full=1, overflow=1, count=16; pop -> dout=15 (0xFF not stored).
- Pop on empty -> valid=0, dout holds previous value, underflow=1; assert clr_err alone -> underflow=0; clr_err with pop on empty same cycle -> underflow stays 1.
- Same-cycle push+pop with count=2 (top 0x22) and din=0x44 -> push wins: count=3, valid=0; next pop -> 0x44. Flush+push same cycle -> count=0.
- Assert rst low while valid high after a pop with count=5 -> immediately valid=0, dout=0, count=0, flags 0; after release, push 0x01/pop returns 0x01.
